mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 19 +
 rtl/mem_arbiter.sv | 168 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-port data-memory arbiter: memory write-width
// codes and the arbiter FSM state encoding.
package mem_arbiter_pkg;

    localparam int MEMWRWIDTH_W = 2;

    typedef logic [MEMWRWIDTH_W-1:0] mem_width_t;

    localparam mem_width_t WIDTH_WORD  = 2'd0;
    localparam mem_width_t WIDTH_HWORD = 2'd1;
    localparam mem_width_t WIDTH_BYTE  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOCK0 = 2'd1,
        ST_LOCK1 = 2'd2
    } arb_state_e;

endpackage

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a single data memory, with
// lockable bursts bounded by MAX_BURST and one-cycle registered read responses.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int MAX_BURST = 8
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    rq0_valid,
    output logic                    rq0_ready,
    input  logic                    rq0_we,
    input  logic                    rq0_lock,
    input  logic [31:0]             rq0_addr,
    input  logic [31:0]             rq0_wdata,
    input  logic [MEMWRWIDTH_W-1:0] rq0_width,

    input  logic                    rq1_valid,
    output logic                    rq1_ready,
    input  logic                    rq1_we,
    input  logic                    rq1_lock,
    input  logic [31:0]             rq1_addr,
    input  logic [31:0]             rq1_wdata,
    input  logic [MEMWRWIDTH_W-1:0] rq1_width,

    output logic                    rs0_valid,
    output logic [31:0]             rs0_rdata,
    output logic                    rs1_valid,
    output logic [31:0]             rs1_rdata,

    output logic                    mem_write_en,
    output logic [31:0]             mem_addr,
    output logic [31:0]             mem_din,
    output logic [MEMWRWIDTH_W-1:0] mem_write_width,
    input  logic [31:0]             mem_dout
);

    localparam int             CNT_W   = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);

    arb_state_e       state;
    logic             rr;
    logic [CNT_W-1:0] cnt;

    logic gnt0, gnt1;
    logic xfer0, xfer1;
    logic burst_full;

    assign burst_full = (cnt == CNT_MAX);

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (rq0_valid && rq1_valid) begin
                    gnt0 = ~rr;
                    gnt1 = rr;
                end else begin
                    gnt0 = rq0_valid;
                    gnt1 = rq1_valid;
                end
            end
            // A full burst yields exactly one slot to a waiting partner.
            ST_LOCK0: begin
                if (burst_full && rq1_valid) gnt1 = 1'b1;
                else                         gnt0 = rq0_valid;
            end
            ST_LOCK1: begin
                if (burst_full && rq0_valid) gnt0 = 1'b1;
                else                         gnt1 = rq1_valid;
            end
            default: ;
        endcase
    end

    assign rq0_ready = gnt0 & ~rst;
    assign rq1_ready = gnt1 & ~rst;
    assign xfer0     = rq0_valid & rq0_ready;
    assign xfer1     = rq1_valid & rq1_ready;

    always_comb begin
        mem_write_en    = 1'b0;
        mem_addr        = '0;
        mem_din         = '0;
        mem_write_width = '0;
        if (xfer0) begin
            mem_write_en    = rq0_we;
            mem_addr        = rq0_addr;
            mem_din         = rq0_wdata;
            mem_write_width = rq0_width;
        end else if (xfer1) begin
            mem_write_en    = rq1_we;
            mem_addr        = rq1_addr;
            mem_din         = rq1_wdata;
            mem_write_width = rq1_width;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            rr        <= 1'b0;
            cnt       <= '0;
            rs0_valid <= 1'b0;
            rs1_valid <= 1'b0;
            rs0_rdata <= '0;
            rs1_rdata <= '0;
        end else begin
            rs0_valid <= xfer0 & ~rq0_we;
            rs1_valid <= xfer1 & ~rq1_we;
            if (xfer0 && !rq0_we) rs0_rdata <= mem_dout;
            if (xfer1 && !rq1_we) rs1_rdata <= mem_dout;

            unique case (state)
                ST_IDLE: begin
                    if (xfer0) begin
                        rr <= 1'b1;
                        if (rq0_lock) begin
                            state <= ST_LOCK0;
                            cnt   <= CNT_W'(1);
                        end
                    end else if (xfer1) begin
                        rr <= 1'b0;
                        if (rq1_lock) begin
                            state <= ST_LOCK1;
                            cnt   <= CNT_W'(1);
                        end
                    end
                end
                ST_LOCK0: begin
                    if (xfer1) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                        rr    <= 1'b0;
                    end else if (xfer0 && rq0_lock) begin
                        if (!burst_full) cnt <= cnt + 1'b1;
                    end else begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                        rr    <= 1'b1;
                    end
                end
                ST_LOCK1: begin
                    if (xfer0) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                        rr    <= 1'b1;
                    end else if (xfer1 && rq1_lock) begin
                        if (!burst_full) cnt <= cnt + 1'b1;
                    end else begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                        rr    <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: table-driven arbitration vectors plus
// directed sequences for write/read, burst limit, saturation, reset and byte lanes.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        rq0_valid, rq0_we, rq0_lock, rq1_valid, rq1_we, rq1_lock;
    logic        rq0_ready, rq1_ready;
    logic [31:0] rq0_addr, rq0_wdata, rq1_addr, rq1_wdata;
    logic [MEMWRWIDTH_W-1:0] rq0_width, rq1_width;
    logic        rs0_valid, rs1_valid;
    logic [31:0] rs0_rdata, rs1_rdata;
    logic        mem_write_en;
    logic [31:0] mem_addr, mem_din, mem_dout;
    logic [MEMWRWIDTH_W-1:0] mem_write_width;

    int num_checks = 0;
    int num_errors = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.MAX_BURST(8)) dut (
        .clk(clk), .rst(rst),
        .rq0_valid(rq0_valid), .rq0_ready(rq0_ready), .rq0_we(rq0_we), .rq0_lock(rq0_lock),
        .rq0_addr(rq0_addr), .rq0_wdata(rq0_wdata), .rq0_width(rq0_width),
        .rq1_valid(rq1_valid), .rq1_ready(rq1_ready), .rq1_we(rq1_we), .rq1_lock(rq1_lock),
        .rq1_addr(rq1_addr), .rq1_wdata(rq1_wdata), .rq1_width(rq1_width),
        .rs0_valid(rs0_valid), .rs0_rdata(rs0_rdata),
        .rs1_valid(rs1_valid), .rs1_rdata(rs1_rdata),
        .mem_write_en(mem_write_en), .mem_addr(mem_addr), .mem_din(mem_din),
        .mem_write_width(mem_write_width), .mem_dout(mem_dout)
    );

    // Little-endian data memory model: combinational read, lane writes on the edge.
    logic [31:0] mem_model [0:63];
    assign mem_dout = mem_model[mem_addr[7:2]];

    always @(posedge clk) begin
        if (mem_write_en) begin
            case (mem_write_width)
                WIDTH_BYTE:  mem_model[mem_addr[7:2]][mem_addr[1:0]*8 +: 8] <= mem_din[7:0];
                WIDTH_HWORD: mem_model[mem_addr[7:2]][mem_addr[1]*16 +: 16] <= mem_din[15:0];
                default:     mem_model[mem_addr[7:2]] <= mem_din;
            endcase
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        num_checks++;
        if (act !== exp) begin
            num_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        rq0_valid = 0; rq0_we = 0; rq0_lock = 0; rq0_addr = '0; rq0_wdata = '0; rq0_width = WIDTH_WORD;
        rq1_valid = 0; rq1_we = 0; rq1_lock = 0; rq1_addr = '0; rq1_wdata = '0; rq1_width = WIDTH_WORD;
    endtask

    task automatic do_reset();
        set_idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    typedef struct {
        logic v0, v1, l0, l1;
        logic exp_r0, exp_r1;
    } vec_t;

    vec_t vecs [14];

    initial begin
        // Arbitration sequence from reset; expected grants traced by hand from rr/lock rules.
        vecs[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[11] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[12] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[13] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

        set_idle();
        rst = 1'b1;
        rq0_valid = 1; rq1_valid = 1;
        tick();
        check("ready_during_rst", {30'd0, rq0_ready, rq1_ready}, 32'd0);
        check("mem_we_during_rst", {31'd0, mem_write_en}, 32'd0);
        check("rs_valid_reset", {30'd0, rs0_valid, rs1_valid}, 32'd0);
        check("rs0_rdata_reset", rs0_rdata, 32'd0);
        check("rs1_rdata_reset", rs1_rdata, 32'd0);
        rst = 1'b0;
        set_idle();

        // Table-driven arbitration; odd addresses exercise misaligned pass-through.
        for (int i = 0; i < 14; i++) begin
            logic [31:0] exp_addr;
            rq0_valid = vecs[i].v0; rq0_lock = vecs[i].l0; rq0_addr = 32'h100 + i;
            rq1_valid = vecs[i].v1; rq1_lock = vecs[i].l1; rq1_addr = 32'h200 + i;
            exp_addr = vecs[i].exp_r0 ? 32'h100 + i : (vecs[i].exp_r1 ? 32'h200 + i : 32'd0);
            #1;
            check($sformatf("vec%0d_grant", i), {30'd0, rq0_ready, rq1_ready},
                  {30'd0, vecs[i].exp_r0, vecs[i].exp_r1});
            check($sformatf("vec%0d_addr", i), mem_addr, exp_addr);
            check($sformatf("vec%0d_we", i), {31'd0, mem_write_en}, 32'd0);
            tick();
            check($sformatf("vec%0d_rsvalid", i), {30'd0, rs0_valid, rs1_valid},
                  {30'd0, vecs[i].exp_r0, vecs[i].exp_r1});
        end
        set_idle();

        // Port 0 writes a word, port 1 reads it back.
        do_reset();
        rq0_valid = 1; rq0_we = 1; rq0_addr = 32'h10; rq0_wdata = 32'hDEADBEEF; rq0_width = WIDTH_WORD;
        #1;
        check("wr_ready0", {31'd0, rq0_ready}, 32'd1);
        check("wr_mem_we", {31'd0, mem_write_en}, 32'd1);
        check("wr_mem_din", mem_din, 32'hDEADBEEF);
        tick();
        check("wr_no_resp", {30'd0, rs0_valid, rs1_valid}, 32'd0);
        set_idle();
        rq1_valid = 1; rq1_addr = 32'h10;
        #1;
        check("rd_ready1", {31'd0, rq1_ready}, 32'd1);
        tick();
        set_idle();
        check("rd_rs1_valid", {31'd0, rs1_valid}, 32'd1);
        check("rd_rs0_quiet", {31'd0, rs0_valid}, 32'd0);
        check("rd_rs1_rdata", rs1_rdata, 32'hDEADBEEF);
        tick();
        check("rd_rs1_one_cycle", {31'd0, rs1_valid}, 32'd0);
        check("rd_rs1_hold", rs1_rdata, 32'hDEADBEEF);

        // Locked burst on port 0 with port 1 waiting: 8 grants, 1 yield, then port 0 again.
        do_reset();
        rq0_valid = 1; rq0_lock = 1; rq0_addr = 32'h40;
        rq1_valid = 1; rq1_addr = 32'h44;
        for (int i = 0; i < 10; i++) begin
            #1;
            check($sformatf("burst%0d_grant", i), {30'd0, rq0_ready, rq1_ready},
                  (i == 8) ? 32'd1 : 32'd2);
            tick();
        end
        set_idle();

        // Port 1 lock alone for 20 cycles: never interrupted, counter saturates.
        do_reset();
        rq1_valid = 1; rq1_lock = 1; rq1_addr = 32'h48;
        for (int i = 0; i < 20; i++) begin
            #1;
            check($sformatf("sat%0d_grant", i), {30'd0, rq0_ready, rq1_ready}, 32'd1);
            tick();
        end
        check("sat_cnt", {28'd0, dut.cnt}, 32'd8);
        rq0_valid = 1; rq0_addr = 32'h4C;
        #1;
        check("sat_yield_to_p0", {30'd0, rq0_ready, rq1_ready}, 32'd2);
        tick();
        set_idle();

        // Reset pulsed during a write, with a read response pending.
        do_reset();
        rq0_valid = 1; rq0_we = 1; rq0_addr = 32'h20; rq0_wdata = 32'h11111111;
        tick();
        rq0_we = 0; rq0_addr = 32'h10;
        tick();
        rq0_we = 1; rq0_addr = 32'h20; rq0_wdata = 32'h22222222;
        rst = 1'b1;
        #1;
        check("rst_no_ready", {31'd0, rq0_ready}, 32'd0);
        check("rst_no_write", {31'd0, mem_write_en}, 32'd0);
        tick();
        rst = 1'b0;
        check("rst_mem_unchanged", mem_model[8], 32'h11111111);
        check("rst_rs_valid", {30'd0, rs0_valid, rs1_valid}, 32'd0);
        check("rst_rs0_rdata", rs0_rdata, 32'd0);
        set_idle();
        rq0_valid = 1; rq1_valid = 1;
        #1;
        check("rst_first_grant_p0", {30'd0, rq0_ready, rq1_ready}, 32'd2);
        tick();
        set_idle();

        // Byte write into lane 3, then back-to-back word reads of the same word.
        do_reset();
        rq0_valid = 1; rq0_we = 1; rq0_addr = 32'h13; rq0_wdata = 32'h000000AB; rq0_width = WIDTH_BYTE;
        #1;
        check("byte_width", {30'd0, mem_write_width}, {30'd0, WIDTH_BYTE});
        check("byte_addr", mem_addr, 32'h13);
        tick();
        rq0_we = 0; rq0_addr = 32'h10; rq0_width = WIDTH_WORD;
        tick();
        check("b2b_rs0_valid_a", {31'd0, rs0_valid}, 32'd1);
        check("byte_lane3", {24'd0, rs0_rdata[31:24]}, 32'hAB);
        check("byte_word", rs0_rdata, 32'hABADBEEF);
        tick();
        set_idle();
        check("b2b_rs0_valid_b", {31'd0, rs0_valid}, 32'd1);
        tick();
        check("b2b_rs0_done", {31'd0, rs0_valid}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
        $finish;
    end

endmodule
